sweep_ctrl: RTL and testbench
=============================

Name: sweep_ctrl

Overview:
Sequencer for the NBIT up/down counter datapath. It drives the counter's direction, enable and clear so that the count sweeps as a triangle between two programmable limits. The sweep has a programmable dwell at each turnaround and a programmable number of sweeps. It sits between a host/config interface and the counter, and observes the counter's q output to decide transitions.

Parameters:
NBIT, 5, counter width; width of q, lo_lim, hi_lim
DW, 8, dwell counter width
CW, 8, sweep-count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep run; sampled in IDLE only
stop  input  1  abort the current run
lo_lim  input  NBIT  lower turnaround value; sampled at accepted start
hi_lim  input  NBIT  upper turnaround value; sampled at accepted start
dwell  input  DW  hold cycles at each turnaround; 0 = no hold; sampled at start
n_sweeps  input  CW  full up+down sweeps to run; 0 = run until stop; sampled at start
q  input  NBIT  current counter value, fed back from the counter
up_down  output  1  counter direction; 1 = up
cnt_en  output  1  counter step enable
cnt_clr  output  1  synchronous counter clear; takes priority over cnt_en
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when n_sweeps have completed
err  output  1  one-cycle pulse when start is rejected
sweep_cnt  output  CW  completed sweeps in the current or last run
state  output  3  state encoding, for debug

Behaviour:
- Counter contract: on a rising edge, cnt_clr=1 sets q to 0. Otherwise, cnt_en=1 steps q by +1 if up_down=1, or by -1 if up_down=0.
- Reset (asynchronous): state=IDLE; lo/hi/dwell/n registers=0; dwell counter=0; sweep_cnt=0.
- Output values during reset: cnt_en=0, cnt_clr=0, up_down=1, busy=0, done=0, err=0.
- Reset mid-run: outputs go to the reset values immediately, without waiting for a clock edge.
- States: IDLE=0, CLR=1, SEEK=2, UP=3, HOLD_HI=4, DOWN=5, HOLD_LO=6, DONE=7.
- Output decode: cnt_en, cnt_clr and up_down are combinational from state and q. All registers update on the clock edge.
- IDLE, start=1, hi_lim>lo_lim: latch lo/hi/dwell/n, clear sweep_cnt, go to CLR.
- IDLE, start=1, hi_lim<=lo_lim: pulse err for one cycle, stay in IDLE, leave sweep_cnt unchanged.
- CLR: cnt_clr=1 for one cycle, then SEEK.
- SEEK: up_down=1, cnt_en=(q!=lo_r). When q==lo_r, go to UP.
- UP: up_down=1, cnt_en=(q!=hi_r). When q==hi_r:
  - dwell_r==0: go to DOWN.
  - otherwise: load the dwell counter with dwell_r and go to HOLD_HI.
- HOLD_HI: cnt_en=0, up_down=1. Decrement the dwell counter each cycle. After exactly dwell_r cycles, go to DOWN.
- DOWN: up_down=0, cnt_en=(q!=lo_r). When q==lo_r:
  - sweep_cnt increments by 1.
  - If n_r!=0 and the new sweep_cnt==n_r: go to DONE.
  - Else if dwell_r==0: go to UP.
  - Else: load the dwell counter and go to HOLD_LO.
- HOLD_LO: same rules as HOLD_HI, with up_down=0. Exit to UP.
- DONE: done=1 for one cycle, then IDLE. sweep_cnt holds its value until the next accepted start.
- Turnaround cost: each limit costs one extra cycle with cnt_en=0 (the compare cycle), in addition to the dwell.
- stop=1 in any non-IDLE state: go to IDLE on the next edge. cnt_en and cnt_clr are forced to 0 in that same cycle.
  - stop wins over a simultaneous DONE or limit transition; done is not pulsed.
  - sweep_cnt keeps its value.
- start while busy is ignored, with no err pulse. start and stop together in IDLE: start wins.
- sweep_cnt wraps modulo 2^CW in continuous mode (n=0).
- Inputs lo_lim, hi_lim, dwell and n_sweeps changing mid-run have no effect.
- The lo_r==0 case is legal: SEEK exits on its first cycle.

Test Plan:
1. NBIT=5, lo=2, hi=5, dwell=2, n=1, start pulsed in cycle 0, counter model attached. Required sequence:
   - Cycle 1: CLR.
   - Cycles 2-4: SEEK (q 0→2).
   - Cycles 5-8: UP (q reaches 5).
   - Cycles 9-10: HOLD_HI.
   - Cycles 11-14: DOWN (q reaches 2).
   - Cycle 15: done=1, sweep_cnt=1.
   - Cycle 16: IDLE.
2. lo=0, hi=31, dwell=0, n=2: q runs 0→31→0→31→0 with no hold cycles. Exactly one cnt_en=0 cycle at each limit. done is pulsed with sweep_cnt=2.
3. lo=7, hi=7, then lo=9, hi=3: err is pulsed for one cycle, state stays IDLE, cnt_clr is never asserted.
4. n=0, lo=1, hi=3, dwell=1, stop asserted after 40 cycles: state=IDLE and cnt_en=0 the next cycle. done never pulses. sweep_cnt equals the number of completed sweeps.
5. rst asserted asynchronously mid-DOWN: busy, cnt_en and sweep_cnt go to 0 before the next edge. After rst is released, a new start runs a full sequence normally.
6. start re-pulsed during UP, with lo_lim/hi_lim inputs changed mid-run: no effect; the sweep continues on the latched limits.

Source files
------------

// File: rtl/sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sweep_ctrl_if
// Description : Host/config and counter-side signal bundle for sweep_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface sweep_ctrl_if #(
    parameter int NBIT = 5,
    parameter int DW   = 8,
    parameter int CW   = 8
);
    logic            start;
    logic            stop;
    logic [NBIT-1:0] lo_lim;
    logic [NBIT-1:0] hi_lim;
    logic [DW-1:0]   dwell;
    logic [CW-1:0]   n_sweeps;
    logic [NBIT-1:0] q;
    logic            up_down;
    logic            cnt_en;
    logic            cnt_clr;
    logic            busy;
    logic            done;
    logic            err;
    logic [CW-1:0]   sweep_cnt;
    logic [2:0]      state;

    // Host plus counter side: drives requests and the fed-back count.
    modport master (
        output start, stop, lo_lim, hi_lim, dwell, n_sweeps, q,
        input  up_down, cnt_en, cnt_clr, busy, done, err, sweep_cnt, state
    );

    modport slave (
        input  start, stop, lo_lim, hi_lim, dwell, n_sweeps, q,
        output up_down, cnt_en, cnt_clr, busy, done, err, sweep_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sweep_ctrl
// Description : Drives an up/down counter as a triangle sweep between two
//               latched limits, with turnaround dwell and sweep counting.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_ctrl #(
    parameter int NBIT = 5,
    parameter int DW   = 8,
    parameter int CW   = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_SEEK    = 3'd2,
        S_UP      = 3'd3,
        S_HOLD_HI = 3'd4,
        S_DOWN    = 3'd5,
        S_HOLD_LO = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t          r_state;
    logic [NBIT-1:0] r_lo;
    logic [NBIT-1:0] r_hi;
    logic [DW-1:0]   r_dwell;
    logic [DW-1:0]   r_dwell_cnt;
    logic [CW-1:0]   r_n;
    logic [CW-1:0]   r_sweep_cnt;
    logic            r_err;

    logic            w_abort;
    logic            w_at_lo;
    logic            w_at_hi;
    logic [CW-1:0]   w_sweep_next;
    logic            w_up_down;
    logic            w_cnt_en;
    logic            w_cnt_clr;

    // stop only has meaning once a run is in progress; in IDLE start wins.
    assign w_abort      = bus.stop && (r_state != S_IDLE);
    assign w_at_lo      = (bus.q == r_lo);
    assign w_at_hi      = (bus.q == r_hi);
    assign w_sweep_next = r_sweep_cnt + CW'(1);

    always_comb begin
        w_up_down = 1'b1;
        w_cnt_en  = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            S_CLR:     w_cnt_clr = 1'b1;
            S_SEEK:    w_cnt_en  = !w_at_lo;
            S_UP:      w_cnt_en  = !w_at_hi;
            S_DOWN: begin
                w_up_down = 1'b0;
                w_cnt_en  = !w_at_lo;
            end
            S_HOLD_LO: w_up_down = 1'b0;
            default:   ;
        endcase
        if (w_abort) begin
            w_cnt_en  = 1'b0;
            w_cnt_clr = 1'b0;
        end
    end

    assign bus.up_down   = w_up_down;
    assign bus.cnt_en    = w_cnt_en;
    assign bus.cnt_clr   = w_cnt_clr;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE) && !bus.stop;
    assign bus.err       = r_err;
    assign bus.sweep_cnt = r_sweep_cnt;
    assign bus.state     = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_n         <= '0;
            r_sweep_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (bus.hi_lim > bus.lo_lim) begin
                                r_lo        <= bus.lo_lim;
                                r_hi        <= bus.hi_lim;
                                r_dwell     <= bus.dwell;
                                r_n         <= bus.n_sweeps;
                                r_sweep_cnt <= '0;
                                r_state     <= S_CLR;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_CLR: r_state <= S_SEEK;
                    S_SEEK: begin
                        if (w_at_lo) r_state <= S_UP;
                    end
                    S_UP: begin
                        if (w_at_hi) begin
                            if (r_dwell == '0) begin
                                r_state <= S_DOWN;
                            end else begin
                                r_dwell_cnt <= r_dwell;
                                r_state     <= S_HOLD_HI;
                            end
                        end
                    end
                    S_HOLD_HI: begin
                        // Counter was loaded with dwell, so exit on its last count.
                        r_dwell_cnt <= r_dwell_cnt - DW'(1);
                        if (r_dwell_cnt <= DW'(1)) r_state <= S_DOWN;
                    end
                    S_DOWN: begin
                        if (w_at_lo) begin
                            r_sweep_cnt <= w_sweep_next;
                            if ((r_n != '0) && (w_sweep_next == r_n)) begin
                                r_state <= S_DONE;
                            end else if (r_dwell == '0) begin
                                r_state <= S_UP;
                            end else begin
                                r_dwell_cnt <= r_dwell;
                                r_state     <= S_HOLD_LO;
                            end
                        end
                    end
                    S_HOLD_LO: begin
                        r_dwell_cnt <= r_dwell_cnt - DW'(1);
                        if (r_dwell_cnt <= DW'(1)) r_state <= S_UP;
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_ctrl
// Description : Randomized bench for sweep_ctrl with an attached counter and
//               a trace-based expected-output model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_ctrl;

    localparam int NBIT = 5;
    localparam int DW   = 8;
    localparam int CW   = 8;

    typedef struct {
        int cyc;
        int st;
        int q;    // -1: not checked
        int en;
        int clr;
        int ud;   // -1: not checked
        int done;
        int sw;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   last_sweep;
    int   m_err_cyc;
    int   bc;
    int   c0;
    exp_t exp_q[$];
    exp_t cur;

    sweep_ctrl_if #(.NBIT(NBIT), .DW(DW), .CW(CW)) bus ();

    sweep_ctrl #(.NBIT(NBIT), .DW(DW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The counter the sequencer controls.
    always @(posedge clk or posedge rst) begin
        if (rst)              bus.q <= '0;
        else if (bus.cnt_clr) bus.q <= '0;
        else if (bus.cnt_en)  bus.q <= bus.up_down ? bus.q + 5'd1 : bus.q - 5'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void push(int st, int q, int en, int clr, int ud, int dn, int sw);
        exp_t e;
        e = '{cyc: bc, st: st, q: q, en: en, clr: clr, ud: ud, done: dn, sw: sw};
        exp_q.push_back(e);
        bc++;
    endfunction

    // Expected per-cycle trace of an accepted run starting after cycle s.
    function automatic void build(int s, int lo, int hi, int dw, int n, int max_len);
        int sc;
        sc = 0;
        bc = s + 1;
        push(1, -1, 0, 1, -1, 0, 0);
        for (int v = 0; v <= lo; v++) push(2, v, int'(v != lo), 0, 1, 0, sc);
        while (bc <= s + max_len) begin
            for (int v = lo; v <= hi; v++) push(3, v, int'(v != hi), 0, 1, 0, sc);
            for (int k = 0; k < dw; k++)   push(4, hi, 0, 0, 1, 0, sc);
            for (int v = hi; v >= lo; v--) push(5, v, int'(v != lo), 0, 0, 0, sc);
            sc = (sc + 1) % 256;
            if (n != 0 && sc == n) begin
                push(7, lo, 0, 0, -1, 1, sc);
                break;
            end
            for (int k = 0; k < dw; k++)   push(6, lo, 0, 0, 0, 0, sc);
        end
    endfunction

    // stop in cycle c: that cycle steps nothing and the run ends there.
    function automatic void apply_stop(int c);
        exp_t tmp[$];
        exp_t e;
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc <= c) begin
                e = exp_q[i];
                if (e.cyc == c) begin
                    e.en   = 0;
                    e.clr  = 0;
                    e.done = 0;
                end
                tmp.push_back(e);
            end
        end
        exp_q = tmp;
    endfunction

    function automatic bit model_busy();
        return (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    endfunction

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                cur = exp_q.pop_front();
                last_sweep = cur.sw;
            end else begin
                cur = '{cyc: cyc, st: 0, q: -1, en: 0, clr: 0, ud: 1, done: 0, sw: last_sweep};
            end
            check("state",     32'(bus.state),     32'(cur.st));
            check("busy",      32'(bus.busy),      32'(cur.st != 0));
            check("cnt_en",    32'(bus.cnt_en),    32'(cur.en));
            check("cnt_clr",   32'(bus.cnt_clr),   32'(cur.clr));
            check("done",      32'(bus.done),      32'(cur.done));
            check("err",       32'(bus.err),       32'(cyc == m_err_cyc));
            check("sweep_cnt", 32'(bus.sweep_cnt), 32'(cur.sw));
            if (cur.ud >= 0) check("up_down", 32'(bus.up_down), 32'(cur.ud));
            if (cur.q >= 0)  check("q",       32'(bus.q),       32'(cur.q));
        end
    end

    task automatic scramble();
        bus.lo_lim   = 5'($urandom_range(0, 31));
        bus.hi_lim   = 5'($urandom_range(0, 31));
        bus.dwell    = 8'($urandom_range(0, 255));
        bus.n_sweeps = 8'($urandom_range(0, 255));
    endtask

    task automatic step();
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic do_start(int lo, int hi, int dw, int n, int max_len, bit with_stop);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.stop     = with_stop;
        bus.lo_lim   = 5'(lo);
        bus.hi_lim   = 5'(hi);
        bus.dwell    = 8'(dw);
        bus.n_sweeps = 8'(n);
        c0 = cyc;
        if (hi > lo) build(c0, lo, hi, dw, n, max_len);
        else         m_err_cyc = c0 + 1;
        step();
        scramble();
    endtask

    task automatic run_wait(int budget, int stop_at, int stop_pct, int start_pct);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            step();
            scramble();
            if (model_busy()) begin
                if (int'($urandom_range(0, 99)) < start_pct) bus.start = 1'b1;
                if (k == stop_at || int'($urandom_range(0, 99)) < stop_pct) begin
                    bus.stop = 1'b1;
                    apply_stop(cyc);
                end
            end
            k++;
            if (k > budget) begin
                check("run_timeout", 32'(k), 32'(budget));
                exp_q.delete();
            end
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en0;
        int t1_states[16];
        int lo, hi, dw, n;
        checks     = 0;
        errors     = 0;
        last_sweep = 0;
        m_err_cyc  = -1;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        scramble();
        t1_states = '{1, 2, 2, 2, 3, 3, 3, 3, 4, 4, 5, 5, 5, 5, 7, 0};

        // Reset values
        #22;
        check("rst_state",   32'(bus.state),     32'd0);
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_cnt_en",  32'(bus.cnt_en),    32'd0);
        check("rst_cnt_clr", 32'(bus.cnt_clr),   32'd0);
        check("rst_up_down", 32'(bus.up_down),   32'd1);
        check("rst_done",    32'(bus.done),      32'd0);
        check("rst_err",     32'(bus.err),       32'd0);
        check("rst_sweep",   32'(bus.sweep_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: lo=2 hi=5 dwell=2 n=1, literal cycle-by-cycle states
        do_start(2, 5, 2, 1, 400, 1'b0);
        check("t1_model_len",  32'(exp_q.size()),  32'd15);
        check("t1_model_done", 32'(exp_q[14].done), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) step();
            #3;
            check("t1_state", 32'(bus.state), 32'(t1_states[k-1]));
            if (k == 15) begin
                check("t1_done",  32'(bus.done),      32'd1);
                check("t1_sweep", 32'(bus.sweep_cnt), 32'd1);
            end
        end
        step();

        // 2: full-range two sweeps, no dwell
        do_start(0, 31, 0, 2, 400, 1'b0);
        check("t2_model_len", 32'(exp_q.size()), 32'd131);
        en0 = 0;
        foreach (exp_q[i])
            if ((exp_q[i].st == 3 || exp_q[i].st == 5) && exp_q[i].en == 0) en0++;
        check("t2_limit_idles", 32'(en0), 32'd4);
        run_wait(200, -1, 0, 0);

        // 3: rejected starts
        do_start(7, 7, 0, 1, 400, 1'b0);
        #3;
        check("t3_err_eq",   32'(bus.err),   32'd1);
        check("t3_state_eq", 32'(bus.state), 32'd0);
        step();
        do_start(9, 3, 0, 1, 400, 1'b0);
        #3;
        check("t3_err_lt",   32'(bus.err),       32'd1);
        check("t3_sweep_lt", 32'(bus.sweep_cnt), 32'd2);
        step();

        // 4: continuous mode stopped in cycle 40
        do_start(1, 3, 1, 0, 400, 1'b0);
        while (cyc < c0 + 40) step();
        bus.stop = 1'b1;
        apply_stop(cyc);
        step();
        #3;
        check("t4_state",  32'(bus.state),     32'd0);
        check("t4_cnt_en", 32'(bus.cnt_en),    32'd0);
        check("t4_sweep",  32'(bus.sweep_cnt), 32'd4);
        step();

        // 5: async reset mid-DOWN, then a normal run
        do_start(2, 6, 0, 3, 400, 1'b0);
        for (int k = 0; k < 60 && !(model_busy() && exp_q[0].st == 5); k++) step();
        check("t5_reach_down", 32'(model_busy() && exp_q[0].st == 5), 32'd1);
        #3;
        rst = 1'b1;
        exp_q.delete();
        last_sweep = 0;
        m_err_cyc  = -1;
        #1;
        check("t5_busy",    32'(bus.busy),      32'd0);
        check("t5_cnt_en",  32'(bus.cnt_en),    32'd0);
        check("t5_sweep",   32'(bus.sweep_cnt), 32'd0);
        check("t5_up_down", 32'(bus.up_down),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();
        do_start(4, 10, 1, 2, 400, 1'b0);
        run_wait(200, -1, 0, 0);

        // 6: start and limit changes during UP have no effect
        do_start(3, 20, 0, 1, 400, 1'b0);
        for (int k = 0; k < 60 && !(model_busy() && exp_q[0].st == 3); k++) step();
        bus.start  = 1'b1;
        bus.lo_lim = 5'd0;
        bus.hi_lim = 5'd9;
        run_wait(200, -1, 0, 0);

        // sweep_cnt wrap in continuous mode
        do_start(0, 1, 0, 0, 1200, 1'b0);
        run_wait(1300, 1030, 0, 0);

        // Randomized runs
        for (int it = 0; it < 24; it++) begin
            lo = int'($urandom_range(0, 31));
            hi = int'($urandom_range(0, 31));
            dw = int'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 3));
            if (it % 5 == 0) hi = lo;
            do_start(lo, hi, dw, n, 400, $urandom_range(0, 3) == 0);
            if (hi > lo) run_wait(600, (n == 0) ? int'($urandom_range(15, 150)) : -1, 2, 10);
            else         step();
        end

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
